matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Downstream consumer of the operand memory stage. Takes the eight operand bytes it presents (2x2 weight matrix A, 2x2 input matrix B) on a start pulse.
- Snapshots them, computes C = A x B on a 2x2 output-stationary systolic array of signed MAC cells, then streams the four saturated 16-bit results out byte-wise over a valid/ready handshake.
- Sits between the operand memory and the chip's output pins.

Parameters:
DATA_W, 8, operand width (signed two's complement)
ACC_W, 18, internal accumulator width
OUT_W, 16, result width after saturation
(Only the defaults are required to work and to be verified.)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin a job; sampled only in IDLE
weights_flat  input  32  A, row-major: [7:0]=A00 [15:8]=A01 [23:16]=A10 [31:24]=A11
inputs_flat  input  32  B, row-major: [7:0]=B00 [15:8]=B01 [23:16]=B10 [31:24]=B11
out_data  output  8  current result byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts byte when out_valid & out_ready
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse the cycle after the last byte is accepted
sat  output  1  sticky: any result saturated in current/last job; cleared on start accept

Behaviour:
- Reset (async assert) forces: state IDLE, all PE accumulators and pipeline regs 0, out_data=0, out_valid=0, busy=0, done=0, sat=0. Reset mid-job abandons the job with no partial output.
- FSM: IDLE -> LOAD -> COMPUTE -> STREAM -> IDLE.
- IDLE: on start=1, go to LOAD; clear sat; clear all accumulators.
- LOAD (1 cycle): snapshot weights_flat/inputs_flat into internal regs. Later changes on those buses do not affect the job.
- COMPUTE (4 cycles, cnt 0..3): skewed feed at the array edges.
  - Row0 left edge: A00 at cnt0, A01 at cnt1, else 0.
  - Row1 left edge: A10 at cnt1, A11 at cnt2, else 0.
  - Col0 top edge: B00 at cnt0, B10 at cnt1, else 0.
  - Col1 top edge: B01 at cnt1, B11 at cnt2, else 0.
  - Each PE(i,j) each cycle: acc += a_in*b_in (signed 8x8 -> 16, sign-extended to ACC_W). It registers a_in to its right neighbour and b_in to its lower neighbour (1-cycle hop). PE(1,1) receives its last product at cnt3.
- STREAM: results saturated to int16. Greater than 32767 gives 0x7FFF; less than -32768 gives 0x8000. Any clamp sets sat.
  - Byte order: C00[7:0], C00[15:8], C01 lo, C01 hi, C10 lo, C10 hi, C11 lo, C11 hi (8 bytes, index 0..7).
  - out_valid=1 throughout STREAM. The byte index advances only on out_valid&out_ready.
  - While out_ready=0, out_data and out_valid hold stable.
  - Acceptance of byte 7 -> IDLE, out_valid=0 next cycle, done=1 for exactly that cycle.
- Latency: start sampled high at edge k. Array inputs presented at edges k+1..k+5. out_valid is first high after edge k+6, with out_data=C00 lo. Minimum job is 14 cycles with out_ready tied high.
- start while busy: ignored, no queueing. start in the same cycle as done: accepted (FSM is in IDLE).
- sat stays readable after the job until the next accepted start.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/COMPUTE/STREAM), DATA_W/ACC_W/OUT_W, COMPUTE_CYCLES=4, NUM_OUT_BYTES=8, INT16_MAX/INT16_MIN constants.
- One sub-module, mac_pe: ports clk, rst, clr, en, a_in, b_in, a_out, b_out, acc. Instantiated 4 times.
- Feed skew, FSM, saturation and byte mux live in matmul_sequencer.

Test Plan:
- A=[[1,2],[3,4]], B=identity, out_ready=1 -> bytes 01 00 02 00 03 00 04 00. out_valid first high 6 cycles after start; done pulses once; sat=0.
- A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]: bytes 13 00 16 00 2B 00 32 00.
- A=[[-1,0],[0,-1]], B=[[2,3],[4,5]] -> bytes FE FF FD FF FC FF FB FF. Separately, all A=-128 and all B=127 -> each C=-32512: bytes 00 81 x4, sat=0.
- All A and B = -128 -> each true C=32768 -> bytes FF 7F x4, sat=1. Next start clears sat.
- Backpressure: out_ready low for 3 cycles after byte 2 is presented -> out_data stays 0x02 and out_valid stays 1; stream resumes in order. Change weights_flat during COMPUTE -> results unchanged. start pulsed during STREAM -> ignored.
- Assert rst during COMPUTE cnt2 -> immediately busy=0, out_valid=0, out_data=0. A fresh job afterwards gives correct results (no stale accumulation).

Source files
------------

// File: rtl/matmul_sequencer_pkg.sv
// Shared types, sizes and saturation helpers for the 2x2 systolic matmul sequencer.
package matmul_sequencer_pkg;

  localparam int DATA_W         = 8;
  localparam int ACC_W          = 18;
  localparam int OUT_W          = 16;
  localparam int BYTE_W         = 8;
  localparam int COMPUTE_CYCLES = 4;
  localparam int NUM_OUT_BYTES  = 8;
  localparam int INT16_MAX      = 32767;
  localparam int INT16_MIN      = -32768;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    STREAM
  } state_t;

  function automatic logic clamped(input logic signed [ACC_W-1:0] v);
    return (int'(v) > INT16_MAX) || (int'(v) < INT16_MIN);
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (int'(v) > INT16_MAX)
      return OUT_W'(INT16_MAX);
    else if (int'(v) < INT16_MIN)
      return OUT_W'(INT16_MIN);
    else
      return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Job launch operands, byte-stream result handshake and status flags of the sequencer.
interface matmul_sequencer_if;
  import matmul_sequencer_pkg::*;

  logic                  start;
  logic [4*DATA_W-1:0]   weights_flat;
  logic [4*DATA_W-1:0]   inputs_flat;
  logic [BYTE_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic                  sat;

  modport master (
    output start, weights_flat, inputs_flat, out_ready,
    input  out_data, out_valid, busy, done, sat
  );

  modport slave (
    input  start, weights_flat, inputs_flat, out_ready,
    output out_data, out_valid, busy, done, sat
  );

endinterface

// File: rtl/matmul_sequencer_mac_pe.sv
// Output-stationary signed MAC cell: accumulates a_in*b_in and forwards operands one hop.
module mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a_in * b_in;

  // Forwarding regs are cleared with the accumulator so the next job sees no stale operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (clr) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      acc   <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Snapshots A and B, computes C = A x B on a 2x2 systolic array, streams saturated int16 results bytewise.
module matmul_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int OUT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  matmul_sequencer_if.slave bus
);
  import matmul_sequencer_pkg::*;

  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;

  logic clr, load, en, prime, adv, last;

  logic [4*DATA_W-1:0] w_q, x_q;
  logic [BYTE_W-1:0]   out_data_q;
  logic                out_valid_q, done_q, sat_q;

  logic signed [DATA_W-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
  logic signed [DATA_W-1:0] a_left0, a_left1, b_top0, b_top1;
  logic signed [DATA_W-1:0] a_h0, a_h1, b_v0, b_v1;
  logic signed [DATA_W-1:0] a_unused0, a_unused1, b_unused0, b_unused1;
  logic signed [ACC_W-1:0]  acc00, acc01, acc10, acc11;

  logic [OUT_W-1:0]  res [4];
  logic [3:0]        clamp;
  logic [OUT_W-1:0]  word;
  logic [BYTE_W-1:0] next_byte;

  assign a00 = w_q[7:0];
  assign a01 = w_q[15:8];
  assign a10 = w_q[23:16];
  assign a11 = w_q[31:24];
  assign b00 = x_q[7:0];
  assign b01 = x_q[15:8];
  assign b10 = x_q[23:16];
  assign b11 = x_q[31:24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // STREAM spends its first cycle loading the output register, so out_valid is registered.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    clr       = 1'b0;
    load      = 1'b0;
    en        = 1'b0;
    prime     = 1'b0;
    adv       = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          clr       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = COMPUTE;
      end
      COMPUTE: begin
        en = 1'b1;
        if (cnt == 2'(COMPUTE_CYCLES-1)) begin
          idx_nxt   = '0;
          state_nxt = STREAM;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      STREAM: begin
        if (!out_valid_q) begin
          prime = 1'b1;
        end else if (bus.out_ready) begin
          if (idx == 3'(NUM_OUT_BYTES-1)) begin
            last      = 1'b1;
            state_nxt = IDLE;
          end else begin
            adv     = 1'b1;
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Skewed edge feed: row i / column j operands arrive i / j cycles late.
  always_comb begin
    a_left0 = '0;
    a_left1 = '0;
    b_top0  = '0;
    b_top1  = '0;
    if (state == COMPUTE) begin
      unique case (cnt)
        2'd0: begin
          a_left0 = a00;
          b_top0  = b00;
        end
        2'd1: begin
          a_left0 = a01;
          a_left1 = a10;
          b_top0  = b10;
          b_top1  = b01;
        end
        2'd2: begin
          a_left1 = a11;
          b_top1  = b11;
        end
        default: ;
      endcase
    end
  end

  mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) pe00 (
    .clk(clk), .rst(rst), .clr(clr), .en(en),
    .a_in(a_left0), .b_in(b_top0), .a_out(a_h0), .b_out(b_v0), .acc(acc00)
  );

  mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) pe01 (
    .clk(clk), .rst(rst), .clr(clr), .en(en),
    .a_in(a_h0), .b_in(b_top1), .a_out(a_unused0), .b_out(b_v1), .acc(acc01)
  );

  mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) pe10 (
    .clk(clk), .rst(rst), .clr(clr), .en(en),
    .a_in(a_left1), .b_in(b_v0), .a_out(a_h1), .b_out(b_unused0), .acc(acc10)
  );

  mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) pe11 (
    .clk(clk), .rst(rst), .clr(clr), .en(en),
    .a_in(a_h1), .b_in(b_v1), .a_out(a_unused1), .b_out(b_unused1), .acc(acc11)
  );

  always_comb begin
    res[0]   = saturate(acc00);
    res[1]   = saturate(acc01);
    res[2]   = saturate(acc10);
    res[3]   = saturate(acc11);
    clamp[0] = clamped(acc00);
    clamp[1] = clamped(acc01);
    clamp[2] = clamped(acc10);
    clamp[3] = clamped(acc11);
  end

  always_comb begin
    word      = res[idx_nxt[2:1]];
    next_byte = idx_nxt[0] ? word[OUT_W-1:BYTE_W] : word[BYTE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q         <= '0;
      x_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      done_q <= last;
      if (clr)
        sat_q <= 1'b0;
      if (load) begin
        w_q <= bus.weights_flat;
        x_q <= bus.inputs_flat;
      end
      if (prime) begin
        out_valid_q <= 1'b1;
        out_data_q  <= next_byte;
        sat_q       <= |clamp;
      end else if (adv) begin
        out_data_q <= next_byte;
      end else if (last) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed and randomized jobs checked against an arithmetic 2x2 matmul reference model.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  matmul_sequencer_if bus ();

  matmul_sequencer #(.DATA_W(8), .ACC_W(18), .OUT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] w, input logic [31:0] x,
                       output logic [7:0] eb [8], output bit es);
    int a [2][2];
    int b [2][2];
    int c;
    logic [31:0] r;
    es = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        a[i][j] = int'($signed(w[8*(2*i+j) +: 8]));
        b[i][j] = int'($signed(x[8*(2*i+j) +: 8]));
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        c = a[i][0] * b[0][j] + a[i][1] * b[1][j];
        if (c > 32767) begin
          c  = 32767;
          es = 1'b1;
        end else if (c < -32768) begin
          c  = -32768;
          es = 1'b1;
        end
        r = c;
        eb[4*i+2*j]   = r[7:0];
        eb[4*i+2*j+1] = r[15:8];
      end
    end
  endtask

  // mode 0: ready tied high; 1: random ready; 2: stall at byte 2, disturb weights, start during stream
  task automatic run_job(input logic [31:0] w, input logic [31:0] x, input int mode);
    logic [7:0] eb [8];
    bit es;
    int n;
    int cyc;
    int stalls;
    bit pulsed;
    model(w, x, eb, es);
    bus.weights_flat = w;
    bus.inputs_flat  = x;
    bus.out_ready    = 1'b1;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("sat_cleared_on_start", bus.sat, 0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (mode == 2 && c == 3) bus.weights_flat = ~w;
    end
    check("valid_not_early", bus.out_valid, 0);
    @(posedge clk); #1;
    check("first_valid_latency", bus.out_valid, 1);
    n = 0; cyc = 0; stalls = 0; pulsed = 1'b0;
    while (n < 8 && cyc < 100) begin
      check("valid_in_stream", bus.out_valid, 1);
      check($sformatf("byte%0d", n), bus.out_data, eb[n]);
      bus.start = 1'b0;
      if (mode == 1) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else if (mode == 2 && n == 2 && stalls < 3) begin
        bus.out_ready = 1'b0;
        stalls++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (mode == 2 && n == 4 && !pulsed) begin
        bus.start = 1'b1;
        pulsed    = 1'b1;
      end
      if (bus.out_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_complete", n, 8);
    if (mode == 0) check("job_cycles", cyc, 8);
    check("done_pulse", bus.done, 1);
    check("valid_after_last", bus.out_valid, 0);
    check("busy_after_last", bus.busy, 0);
    check("sat_flag", bus.sat, es);
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 0);
    check("idle_not_busy", bus.busy, 0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.weights_flat = '0;
    bus.inputs_flat  = '0;
    bus.out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_sat", bus.sat, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_job(32'h04030201, 32'h01000001, 0); idle_gap();
    run_job(32'h04030201, 32'h08070605, 0); idle_gap();
    run_job(32'hFF0000FF, 32'h05040302, 0); idle_gap();
    run_job(32'h80808080, 32'h7F7F7F7F, 0); idle_gap();
    run_job(32'h80808080, 32'h80808080, 0);
    // start issued in the done cycle; also clears the sticky sat from the previous job
    run_job(32'h04030201, 32'h08070605, 0); idle_gap();
    run_job(32'h04030201, 32'h01000001, 2); idle_gap();

    for (int i = 0; i < 8; i++) begin
      run_job($urandom(), $urandom(), 1);
      if (i % 2 == 1) idle_gap();
    end
    idle_gap();

    bus.weights_flat = 32'h7F7F7F7F;
    bus.inputs_flat  = 32'h7F7F7F7F;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_data", bus.out_data, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_job(32'h04030201, 32'h08070605, 0); idle_gap();

    bus.weights_flat = 32'h04030201;
    bus.inputs_flat  = 32'h08070605;
    bus.out_ready    = 1'b0;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("stream_valid_before_rst", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_stream_valid", bus.out_valid, 0);
    check("rst_stream_data", bus.out_data, 0);
    check("rst_stream_busy", bus.busy, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_job(32'hFF0000FF, 32'h05040302, 0); idle_gap();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
